// File: rtl/ieeedrv_track_sd.sv
// Whole-track SD transfer sequencer for the 4040/8250 IEEE drive.
// Converts the stepper's logical track into a block read/write request
// against the mounted image. Write-back of the buffered track is
// always served before a new track is loaded.
module ieeedrv_track_sd #(
  parameter logic [31:0] LBA_BASE    = 32'd0,
  parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        drv_type,
  input  logic        img_mounted,
  input  logic [7:0]  track,
  input  logic        track_changing,
  input  logic        save_track,
  output logic [31:0] sd_lba,
  output logic [4:0]  sd_blk_cnt,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic [7:0]  loaded_track,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]  target;
  logic        op_wr;
  logic        geo4040;
  logic [15:0] acc;
  logic [7:0]  idx;
  logic        save_q;
  logic        save_pending;
  logic        reload;
  logic        mount_seen;
  logic [23:0] tmo_cnt;

  logic        save_edge, want_wr, want_rd, rd_valid;
  logic        start_wr, start_rd, drop_rd, abort;
  logic        calc_fin, mount_apply, tmo_hit;
  logic [4:0]  sec_idx, sec_tgt;
  logic [15:0] acc_sum, lba_sum;

  // Sectors per track for the selected geometry.
  function automatic logic [4:0] spt(input logic is4040, input logic [7:0] t);
    logic [4:0] s;
    if (is4040) begin
      if (t <= 8'd17)      s = 5'd21;
      else if (t <= 8'd24) s = 5'd19;
      else if (t <= 8'd30) s = 5'd18;
      else                 s = 5'd17;
    end else begin
      if (t <= 8'd39)       s = 5'd29;
      else if (t <= 8'd53)  s = 5'd27;
      else if (t <= 8'd64)  s = 5'd25;
      else if (t <= 8'd77)  s = 5'd23;
      else if (t <= 8'd116) s = 5'd29;
      else if (t <= 8'd130) s = 5'd27;
      else if (t <= 8'd141) s = 5'd25;
      else                  s = 5'd23;
    end
    return s;
  endfunction

  // Highest addressable track; 4040 tracks 36..42 are usable as 17-sector.
  function automatic logic [7:0] max_track(input logic is4040);
    return is4040 ? 8'd42 : 8'd154;
  endfunction

  assign save_edge = save_track ^ save_q;
  assign want_wr   = (save_pending || save_edge) && (loaded_track != 8'd0);
  assign want_rd   = !track_changing && ((track != loaded_track) || reload);
  assign rd_valid  = (track != 8'd0) && (track <= max_track(drv_type));

  assign sec_idx  = spt(geo4040, idx);
  assign sec_tgt  = spt(geo4040, target);
  assign acc_sum  = acc + {11'd0, sec_idx};
  // Target 1 needs no accumulation; otherwise finish while adding track T-1.
  assign calc_fin = (idx >= target) || (idx == target - 8'd1);
  assign lba_sum  = (idx >= target) ? acc : acc_sum;
  assign tmo_hit  = (tmo_cnt == ACK_TIMEOUT - 24'd1);

  // Mount seen during an operation takes effect once it has ended.
  assign mount_apply = ((state == S_DONE) || abort) && (mount_seen || img_mounted);

  assign sd_rd = (state == S_REQ) && !op_wr;
  assign sd_wr = (state == S_REQ) && op_wr;
  assign busy  = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    start_wr = 1'b0;
    start_rd = 1'b0;
    drop_rd  = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!img_mounted) begin
          if (want_wr) begin
            start_wr = 1'b1;
            state_nx = S_CALC;
          end else if (want_rd) begin
            if (rd_valid) begin
              start_rd = 1'b1;
              state_nx = S_CALC;
            end else begin
              drop_rd = 1'b1;
            end
          end
        end
      end
      S_CALC: if (calc_fin) state_nx = S_REQ;
      S_REQ: begin
        if (sd_ack) state_nx = S_XFER;
        else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_XFER: begin
        if (!sd_ack) state_nx = S_DONE;
        else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: request bookkeeping, LBA accumulation, buffer ownership.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      target       <= '0;
      op_wr        <= 1'b0;
      geo4040      <= 1'b0;
      acc          <= '0;
      idx          <= '0;
      save_q       <= save_track;
      save_pending <= 1'b0;
      reload       <= 1'b0;
      mount_seen   <= 1'b0;
      tmo_cnt      <= '0;
      timeout      <= 1'b0;
      sd_lba       <= '0;
      sd_blk_cnt   <= '0;
      loaded_track <= '0;
    end else begin
      save_q  <= save_track;
      timeout <= abort;

      if ((state == S_IDLE) && img_mounted) save_pending <= 1'b0;
      else if (start_wr || mount_apply)     save_pending <= 1'b0;
      else if (save_edge)                   save_pending <= 1'b1;

      if (state == S_IDLE)  mount_seen <= 1'b0;
      else if (img_mounted) mount_seen <= 1'b1;

      if (((state == S_IDLE) && img_mounted) || mount_apply) reload <= 1'b1;
      else if (start_rd || drop_rd)                          reload <= 1'b0;

      if ((state == S_IDLE) && img_mounted) loaded_track <= '0;
      else if (drop_rd || abort)            loaded_track <= '0;
      else if (state == S_DONE) begin
        if (mount_apply) loaded_track <= '0;
        else if (!op_wr) loaded_track <= target;
      end

      if (start_wr || start_rd) begin
        target  <= start_wr ? loaded_track : track;
        op_wr   <= start_wr;
        geo4040 <= drv_type;
        acc     <= '0;
        idx     <= 8'd1;
      end else if (state == S_CALC) begin
        if (calc_fin) begin
          sd_lba     <= LBA_BASE + {16'd0, lba_sum};
          sd_blk_cnt <= sec_tgt - 5'd1;
        end else begin
          acc <= acc_sum;
          idx <= idx + 8'd1;
        end
      end

      if (state_nx != state)                        tmo_cnt <= '0;
      else if ((state == S_REQ) || (state == S_XFER)) tmo_cnt <= tmo_cnt + 24'd1;
    end
  end

endmodule

// File: tb/tb_ieeedrv_track_sd.sv
// Directed bench for ieeedrv_track_sd: acts as the SD host, predicts every
// request from an independent geometry model and checks it via a queue.
module tb_ieeedrv_track_sd;

  localparam int BASE_B = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        drv_type;
  logic        img_mounted;
  logic [7:0]  track;
  logic        track_changing;
  logic        save_track;
  logic        sd_ack;

  logic [31:0] sd_lba, b_lba;
  logic [4:0]  sd_blk_cnt, b_cnt;
  logic        sd_rd, sd_wr, busy, timeout;
  logic        b_rd, b_wr, b_busy, b_timeout;
  logic [7:0]  loaded_track, b_loaded;

  int total = 0;
  int bad = 0;
  int tmo_pulses = 0;

  typedef struct {
    bit wr;
    int lba;
    int lba_b;
    int cnt;
  } req_t;
  req_t sb[$];

  ieeedrv_track_sd #(.LBA_BASE(32'd0), .ACK_TIMEOUT(24'd100)) dut (
    .clk_sys(clk), .reset_n(reset_n), .drv_type(drv_type), .img_mounted(img_mounted),
    .track(track), .track_changing(track_changing), .save_track(save_track),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .loaded_track(loaded_track), .busy(busy), .timeout(timeout)
  );

  ieeedrv_track_sd #(.LBA_BASE(32'd4), .ACK_TIMEOUT(24'd100)) dut_b (
    .clk_sys(clk), .reset_n(reset_n), .drv_type(drv_type), .img_mounted(img_mounted),
    .track(track), .track_changing(track_changing), .save_track(save_track),
    .sd_lba(b_lba), .sd_blk_cnt(b_cnt), .sd_rd(b_rd), .sd_wr(b_wr),
    .sd_ack(sd_ack), .loaded_track(b_loaded), .busy(b_busy), .timeout(b_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeout === 1'b1) tmo_pulses++;

  // The 8250 second half repeats the first-half zone layout 77 tracks later.
  function automatic int spt_m(bit g4040, int t);
    int z;
    if (g4040) return (t < 18) ? 21 : (t < 25) ? 19 : (t < 31) ? 18 : 17;
    z = (t > 77) ? t - 77 : t;
    return (z < 40) ? 29 : (z < 54) ? 27 : (z < 65) ? 25 : 23;
  endfunction

  function automatic int sum_m(bit g4040, int t);
    int s = 0;
    for (int i = 1; i < t; i++) s += spt_m(g4040, i);
    return s;
  endfunction

  task automatic push_req(input bit wr, input bit g4040, input int t);
    req_t r;
    r.wr    = wr;
    r.lba   = sum_m(g4040, t);
    r.lba_b = sum_m(g4040, t) + BASE_B;
    r.cnt   = spt_m(g4040, t) - 1;
    sb.push_back(r);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait for a request (bounded), then pop and compare the prediction.
  task automatic wait_req(output int ticks);
    req_t e;
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (!(sd_rd || sd_wr) && ticks < 400);
    check("req_seen", {63'd0, (sd_rd | sd_wr)}, 64'd1);
    if (sd_rd || sd_wr) begin
      check("rd_wr_excl", {63'd0, (sd_rd & sd_wr)}, 64'd0);
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL sb_pop observed=0 expected=1");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("req_op_wr", {63'd0, sd_wr}, {63'd0, e.wr});
        check("req_lba", {32'd0, sd_lba}, 64'(e.lba));
        check("req_lba_base4", {32'd0, b_lba}, 64'(e.lba_b));
        check("req_blk_cnt", {59'd0, sd_blk_cnt}, 64'(e.cnt));
      end
    end
  endtask

  // Acknowledge the outstanding request, optionally mounting during XFER.
  task automatic complete(input bit mount);
    sd_ack = 1'b1;
    tick();
    check("req_drop_on_ack", {63'd0, (sd_rd | sd_wr)}, 64'd0);
    if (mount) begin
      img_mounted = 1'b1;
      tick();
      img_mounted = 1'b0;
    end
    repeat (2) tick();
    sd_ack = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, busy_seen;

    reset_n = 1'b0; drv_type = 1'b1; img_mounted = 1'b0; track = 8'd0;
    track_changing = 1'b1; save_track = 1'b0; sd_ack = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {sd_rd, sd_wr, busy, timeout, loaded_track, sd_lba, sd_blk_cnt}, 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", {63'd0, busy}, 64'd0);

    // 4040 first read of track 18
    track = 8'd18; track_changing = 1'b0;
    push_req(1'b0, 1'b1, 18);
    wait_req(n);
    check("calc_ticks_t18", 64'(n), 64'd18);
    complete(1'b0);
    check("loaded_18", {56'd0, loaded_track}, 64'd18);
    check("idle_after_18", {63'd0, busy}, 64'd0);

    // save edge and new track in the same cycle: write-back wins
    save_track = ~save_track; track = 8'd19;
    push_req(1'b1, 1'b1, 18);
    push_req(1'b0, 1'b1, 19);
    wait_req(n);
    check("calc_ticks_wr18", 64'(n), 64'd18);
    complete(1'b0);
    check("loaded_after_wr", {56'd0, loaded_track}, 64'd18);
    wait_req(n);
    complete(1'b0);
    check("loaded_19", {56'd0, loaded_track}, 64'd19);

    // head settling blocks loads
    track_changing = 1'b1; track = 8'd20;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy) busy_seen++;
    end
    check("no_req_while_changing", 64'(busy_seen), 64'd0);
    track_changing = 1'b0;
    push_req(1'b0, 1'b1, 20);
    wait_req(n);
    check("start_after_settle", 64'(n), 64'd20);
    complete(1'b0);
    check("loaded_20", {56'd0, loaded_track}, 64'd20);

    // 8250 geometry, including the slowest track
    drv_type = 1'b0; track = 8'd78;
    push_req(1'b0, 1'b0, 78);
    wait_req(n);
    check("calc_ticks_t78", 64'(n), 64'd78);
    complete(1'b0);
    track = 8'd40;
    push_req(1'b0, 1'b0, 40);
    wait_req(n);
    complete(1'b0);
    track = 8'd154;
    push_req(1'b0, 1'b0, 154);
    wait_req(n);
    check("calc_ticks_t154", 64'(n), 64'd154);
    complete(1'b0);
    check("loaded_154", {56'd0, loaded_track}, 64'd154);

    // mount during XFER: transfer finishes, then buffer dropped and reloaded
    track = 8'd41;
    push_req(1'b0, 1'b0, 41);
    wait_req(n);
    complete(1'b1);
    check("loaded_after_mount", {56'd0, loaded_track}, 64'd0);
    push_req(1'b0, 1'b0, 41);
    wait_req(n);
    complete(1'b0);
    check("loaded_reload_41", {56'd0, loaded_track}, 64'd41);

    // host never acknowledges
    track = 8'd1;
    push_req(1'b0, 1'b0, 1);
    wait_req(n);
    check("calc_ticks_t1", 64'(n), 64'd2);
    hi = 1;
    while (sd_rd && hi < 300) begin
      tick();
      if (sd_rd) hi++;
    end
    check("rd_high_cycles", 64'(hi), 64'd100);
    check("loaded_after_timeout", {56'd0, loaded_track}, 64'd0);
    push_req(1'b0, 1'b0, 1);
    wait_req(n);
    check("timeout_pulses", 64'(tmo_pulses), 64'd1);

    // async reset in the middle of a request
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {sd_rd, sd_wr, busy, timeout, loaded_track, sd_lba, sd_blk_cnt}, 64'd0);
    check("async_reset_lba_b", {32'd0, b_lba}, 64'd0);
    tick();
    reset_n = 1'b1;

    // out-of-range track issues nothing
    drv_type = 1'b1; track = 8'd50; track_changing = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || sd_rd || sd_wr) busy_seen++;
    end
    check("invalid_track_no_req", 64'(busy_seen), 64'd0);
    check("invalid_track_loaded", {56'd0, loaded_track}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ieeedrv_track_sd.md
Name: ieeedrv_track_sd

Overview:
Downstream consumer of the stepper/track stage in the 4040/8250 IEEE drive. Takes the logical track number, the track_changing flag and the save_track toggle, and turns them into whole-track SD block read/write requests against the mounted disk image. It computes the image LBA and sector count per track with a sequential accumulator, and serialises saves before loads.

Parameters:
LBA_BASE, 0, block offset added to every computed LBA (image header skip)
ACK_TIMEOUT, 24'hFFFFFF, clk_sys cycles to wait for sd_ack edges before aborting an operation

Ports:
clk_sys  input  1  system clock
reset_n  input  1  asynchronous active-low reset
drv_type  input  1  1 = 4040 geometry, 0 = 8250 geometry
img_mounted  input  1  pulse: new image mounted; invalidates loaded track
track  input  8  logical track from stepper stage (1-based)
track_changing  input  1  head settling; no load may start while high
save_track  input  1  toggle; each edge requests write-back of the loaded track
sd_lba  output  32  block address of current request (256-byte blocks)
sd_blk_cnt  output  5  sectors in track minus 1
sd_rd  output  1  read request
sd_wr  output  1  write request
sd_ack  input  1  SD host acknowledge; high while transfer in progress
loaded_track  output  8  track currently held in buffer, 0 = none
busy  output  1  high whenever state is not IDLE
timeout  output  1  one-cycle pulse when an operation is aborted by timeout

Behaviour:
- Reset (reset_n low, async): state IDLE. sd_rd, sd_wr, busy and timeout are 0. sd_lba = 0, sd_blk_cnt = 0, loaded_track = 0. Save-pending flag cleared. save_track edge detector loads the current save_track value (no spurious save).
- Geometry, 4040 sectors/track: tracks 1-17: 21; 18-24: 19; 25-30: 18; 31-35: 17. Valid tracks are 1..35; higher values up to 42 are treated as 17-sector.
- Geometry, 8250 sectors/track: 1-39: 29; 40-53: 27; 54-64: 25; 65-77: 23; 78-116: 29; 117-130: 27; 131-141: 25; 142-154: 23. Valid tracks are 1..154.
- Track 0 or a track above the maximum is invalid: no request is issued and loaded_track becomes 0.
- LBA computation: LBA = LBA_BASE + sum of sectors of tracks 1..T-1. The sum is built in the CALC state, one track per cycle, with a 16-bit accumulator zero-extended to 32 bits. Worst-case latency is 153 cycles. sd_lba and sd_blk_cnt are registered at CALC exit and held stable until the operation ends.
- save_track edge (either direction) sets save_pending. The flag stays set until the write is issued. Multiple edges before service collapse into one.
- States:
  - IDLE: if save_pending and loaded_track != 0, go to CALC with target = loaded_track and op = write. Otherwise, if !track_changing and track != loaded_track (or the reload flag is set), go to CALC with target = track and op = read. Write has priority over read.
  - CALC: accumulate; on completion go to REQ. For a write, save_pending is cleared at CALC entry.
  - REQ: assert sd_rd or sd_wr. Drop it on the first cycle sd_ack is sampled high, then go to XFER.
  - XFER: wait for sd_ack low, then go to DONE.
  - DONE (1 cycle): on a read, loaded_track <= target. On a write, loaded_track is unchanged. Return to IDLE.
- Timeout: a counter runs in REQ and XFER and resets on each state entry. Reaching ACK_TIMEOUT aborts: request deasserted, timeout pulses, loaded_track <= 0, return to IDLE.
- img_mounted during IDLE: loaded_track <= 0, save_pending cleared, reload flag set.
- img_mounted during CALC, REQ or XFER: the current operation completes; SD transfers are never aborted by a mount. The mount is latched, and at DONE loaded_track <= 0, save_pending is cleared and a reload follows.
- A track change while an operation is in progress does not alter sd_lba. It is picked up on the next IDLE evaluation.
- sd_rd and sd_wr are never high simultaneously, and never high outside REQ.

Test Plan:
- 4040, reset then track=18, track_changing=0 -> CALC takes 17 cycles, then sd_lba=357, sd_blk_cnt=18, sd_rd=1. Ack high, then low -> loaded_track=18, busy=0.
- 8250, track=78 -> sd_lba=2083, sd_blk_cnt=28. With LBA_BASE=4, track=40 -> sd_lba=1135, sd_blk_cnt=26.
- loaded_track=18, toggle save_track and set track=19 in the same cycle -> write at LBA 357 first, loaded_track stays 18. Then read at LBA 376, loaded_track=19.
- track_changing held high with track=20 -> no request while high. Request is issued the cycle after it falls.
- img_mounted pulse during XFER of a read -> transfer completes, then loaded_track=0 and a reload read of the same track is issued.
- sd_ack never asserted (ACK_TIMEOUT=100) -> sd_rd drops after 100 cycles, timeout pulses once, loaded_track=0. Async reset_n low mid-REQ -> all outputs 0 immediately.
